speed_cmd_driver: RTL and testbench

- Command-side initiator for the vehicle speed FSM.
- Drives `keys`, `accelerate` and `brake` into the FSM and reads its 4-bit `Speed` back as feedback.
- Accepts a target speed code over a valid/ready handshake.
- Issues single-cycle accelerate or brake pulses until feedback equals the target, then reports done or a fault code.

---
 rtl/speed_ctrl_pkg.sv | 38 +++
 rtl/speed_settle_timer.sv | 39 +++
 rtl/speed_cmd_driver.sv | 182 ++++++++++++++++++
 tb/tb_speed_cmd_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_ctrl_pkg.sv
// Shared types for the speed command driver and its settle timer.
// Speed codes, fault causes and the driver state encoding.
package speed_ctrl_pkg;

   typedef enum logic [3:0] {
      STOP   = 4'd0,
      MOVE   = 4'd1,
      TURN   = 4'd2,
      SLOW   = 4'd3,
      MEDIUM = 4'd4,
      FAST   = 4'd5,
      FASTER = 4'd6
   } speed_code_t;

   localparam logic [3:0] SPEED_MAX = 4'd6;

   typedef enum logic [2:0] {
      ERR_NONE        = 3'd0,
      ERR_BAD_TARGET  = 3'd1,
      ERR_NO_CONVERGE = 3'd2,
      ERR_BAD_FB      = 3'd3,
      ERR_WDOG        = 3'd4
   } err_code_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COMPARE = 3'd1,
      S_PULSE   = 3'd2,
      S_SETTLE  = 3'd3,
      S_DONE    = 3'd4,
      S_FAULT   = 3'd5
   } drv_state_t;

   function automatic logic code_ok(input logic [3:0] c);
      return c <= SPEED_MAX;
   endfunction

endpackage

// File: rtl/speed_settle_timer.sv
// Post-pulse settle timer: counts down after a pulse and exits early
// as soon as feedback moves away from the value captured at the pulse.
module speed_settle_timer
   import speed_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic       run,
   input  logic [3:0] speed_fb,
   output logic       settled
);

   localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES);

   logic [CW-1:0] settle_cnt;
   logic [3:0]    fb_snap;

   // load on the pulse, saturating countdown while settling
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         settle_cnt <= '0;
         fb_snap    <= '0;
      end else if (load) begin
         settle_cnt <= LOAD_VAL;
         fb_snap    <= speed_fb;
      end else if (run && settle_cnt != '0) begin
         settle_cnt <= settle_cnt - 1'b1;
      end
   end

   assign settled = run && ((speed_fb != fb_snap) ||
                            (settle_cnt <= CW'(1)));

endmodule

// File: rtl/speed_cmd_driver.sv
// Pulses accelerate/brake into the speed FSM until its feedback matches
// a requested code. Optional watchdog: SPEED_CMD_DRIVER_WATCHDOG_EN.
module speed_cmd_driver
   import speed_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int MAX_PULSES    = 8,
   parameter int WDOG_CYCLES   = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_en,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_target,
   input  logic [3:0] speed_fb,
   output logic       keys,
   output logic       accelerate,
   output logic       brake,
   output logic       done,
   output logic       fault,
   output logic [2:0] err_code,
   input  logic       clear_fault
);

   localparam int PW = $clog2(MAX_PULSES + 1);
   localparam logic [PW-1:0] PMAX = PW'(MAX_PULSES);

   drv_state_t    state, state_n;
   err_code_t     err_pend, err_n;
   logic [3:0]    target;
   logic [PW-1:0] pulse_cnt;
   logic          dir_accel;
   logic          hs;
   logic          abort;
   logic          settled;
   logic          wdog_exp;

   assign hs    = (state == S_IDLE) && key_en && req_valid;
   assign abort = !key_en && (state != S_FAULT);

`ifdef SPEED_CMD_DRIVER_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   localparam logic [WW-1:0] WLOAD = WW'(WDOG_CYCLES);

   logic [WW-1:0] wdog_cnt;
   logic          wdog_act;

   assign wdog_act = (state == S_COMPARE) || (state == S_PULSE) ||
                     (state == S_SETTLE);
   assign wdog_exp = wdog_act && (wdog_cnt <= WW'(1));

   // per-request cycle budget, frozen in IDLE and FAULT
   always_ff @(posedge clock) begin
      if (reset || abort) begin
         wdog_cnt <= '0;
      end else if (hs) begin
         wdog_cnt <= WLOAD;
      end else if (state != S_IDLE && state != S_FAULT &&
                   wdog_cnt != '0) begin
         wdog_cnt <= wdog_cnt - 1'b1;
      end
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
   assign wdog_exp    = 1'b0;
`endif

   speed_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle (
      .clock   (clock),
      .reset   (reset),
      .clear   (abort),
      .load    (state == S_PULSE),
      .run     (state == S_SETTLE),
      .speed_fb(speed_fb),
      .settled (settled)
   );

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // next-state and pending fault cause
   always_comb begin
      state_n = state;
      err_n   = err_pend;
      unique case (state)
         S_IDLE: begin
            if (hs) begin
               if (!code_ok(req_target)) begin
                  state_n = S_FAULT;
                  err_n   = ERR_BAD_TARGET;
               end else begin
                  state_n = S_COMPARE;
                  err_n   = ERR_NONE;
               end
            end
         end
         S_COMPARE: begin
            if (!code_ok(speed_fb)) begin
               state_n = S_FAULT;
               err_n   = ERR_BAD_FB;
            end else if (speed_fb == target) begin
               state_n = S_DONE;
            end else if (pulse_cnt == PMAX) begin
               state_n = S_FAULT;
               err_n   = ERR_NO_CONVERGE;
            end else begin
               state_n = S_PULSE;
            end
         end
         S_PULSE:  state_n = S_SETTLE;
         S_SETTLE: if (settled) state_n = S_COMPARE;
         S_DONE:   state_n = S_IDLE;
         S_FAULT: begin
            if (clear_fault) begin
               state_n = S_IDLE;
               err_n   = ERR_NONE;
            end
         end
         default:  state_n = S_IDLE;
      endcase
      if (wdog_exp) begin
         state_n = S_FAULT;
         err_n   = ERR_WDOG;
      end
      if (abort) begin
         state_n = S_IDLE;
         err_n   = ERR_NONE;
      end
   end

   // request latch, pulse count and direction
   always_ff @(posedge clock) begin
      if (reset) begin
         target    <= '0;
         pulse_cnt <= '0;
         dir_accel <= 1'b0;
         err_pend  <= ERR_NONE;
      end else begin
         err_pend <= err_n;
         if (abort) begin
            pulse_cnt <= '0;
         end else if (hs) begin
            target    <= req_target;
            pulse_cnt <= '0;
         end else if (state == S_PULSE && pulse_cnt != PMAX) begin
            pulse_cnt <= pulse_cnt + 1'b1;
         end
         if (state == S_COMPARE) dir_accel <= speed_fb < target;
      end
   end

   // key follower and sticky fault flag
   always_ff @(posedge clock) begin
      if (reset) begin
         keys     <= 1'b0;
         fault    <= 1'b0;
         err_code <= 3'd0;
      end else begin
         keys <= key_en;
         if (state == S_FAULT && !clear_fault) begin
            fault    <= 1'b1;
            err_code <= err_pend;
         end else begin
            fault    <= 1'b0;
            err_code <= 3'd0;
         end
      end
   end

   assign req_ready  = (state == S_IDLE) && key_en;
   assign accelerate = (state == S_PULSE) && dir_accel;
   assign brake      = (state == S_PULSE) && !dir_accel;
   assign done       = (state == S_DONE) && key_en;

endmodule

// File: tb/tb_speed_cmd_driver.sv
// Directed bench for speed_cmd_driver: per-cycle vector table plus
// multi-cycle sequences for pulsing, non-convergence and key-off.
module tb_speed_cmd_driver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       key_en = 1'b0;
   logic       req_valid = 1'b0;
   logic       clear_fault = 1'b0;
   logic [3:0] req_target = 4'd0;
   logic [3:0] fb_drv = 4'd0;
   logic [3:0] model_fb;
   logic [3:0] speed_fb;
   logic       model_en = 1'b0;
   logic       model_rst = 1'b1;
   logic       req_ready, keys, accelerate, brake, done, fault;
   logic [2:0] err_code;
   logic [8:0] outv;

   int checks = 0;
   int errors = 0;

`ifdef SPEED_CMD_DRIVER_WATCHDOG_EN
   localparam int EXP_NP  = 2;
   localparam int EXP_FA  = 12;
   localparam int EXP_ERR = 4;
`else
   localparam int EXP_NP  = 8;
   localparam int EXP_FA  = 51;
   localparam int EXP_ERR = 2;
`endif

   speed_cmd_driver #(
      .SETTLE_CYCLES(4),
      .MAX_PULSES   (8),
      .WDOG_CYCLES  (10)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .key_en     (key_en),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_target (req_target),
      .speed_fb   (speed_fb),
      .keys       (keys),
      .accelerate (accelerate),
      .brake      (brake),
      .done       (done),
      .fault      (fault),
      .err_code   (err_code),
      .clear_fault(clear_fault)
   );

   always #5 clock = ~clock;

   // speed FSM stand-in: STOP goes to SLOW on an accelerate pulse
   always @(posedge clock) begin
      if (model_rst) model_fb <= 4'd0;
      else if (accelerate && model_fb == 4'd0) model_fb <= 4'd3;
   end

   assign speed_fb = model_en ? model_fb : fb_drv;
   assign outv = {keys, req_ready, accelerate, brake, done, fault,
                  err_code};

   typedef struct {
      logic       ken;
      logic       vld;
      logic [3:0] tgt;
      logic [3:0] fb;
      logic       clr;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(input logic ken, input logic vld,
                               input logic [3:0] tgt,
                               input logic [3:0] fb, input logic clr,
                               input logic k, input logic r,
                               input logic a, input logic b,
                               input logic d, input logic f,
                               input logic [2:0] e);
      vec_t v;
      v.ken = ken;
      v.vld = vld;
      v.tgt = tgt;
      v.fb  = fb;
      v.clr = clr;
      v.exp = {k, r, a, b, d, f, e};
      return v;
   endfunction

   task automatic drive(input logic ken, input logic vld,
                        input logic [3:0] tgt, input logic [3:0] fb,
                        input logic clr);
      @(posedge clock);
      #1;
      reset       = 1'b0;
      key_en      = ken;
      req_valid   = vld;
      req_target  = tgt;
      fb_drv      = fb;
      clear_fault = clr;
      @(negedge clock);
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   initial begin
      int acc_n, brk_n, flt_n, acc_first, done_at;
      int fault_at, err_at, bad, first;
      int pulses[$];

      // ken vld tgt fb clr | keys rdy acc brk done fault err
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
      tbl[4]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 1, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[6]  = mk(1, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(1, 0, 9, 0, 0, 1, 0, 0, 0, 0, 1, 1);
      tbl[8]  = mk(0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 1, 1);
      tbl[9]  = mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, 1, 1);
      tbl[10] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[11] = mk(1, 1, 2, 4, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[12] = mk(1, 1, 9, 4, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(1, 0, 2, 4, 0, 1, 0, 0, 1, 0, 0, 0);
      tbl[14] = mk(1, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 2, 2, 0, 1, 0, 0, 0, 1, 0, 0);
      tbl[17] = mk(1, 0, 2, 2, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[18] = mk(1, 1, 3, 8, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[19] = mk(1, 0, 3, 8, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[20] = mk(1, 0, 3, 8, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[21] = mk(1, 0, 3, 8, 0, 1, 0, 0, 0, 0, 1, 3);
      tbl[22] = mk(1, 0, 3, 8, 1, 1, 0, 0, 0, 0, 1, 3);
      tbl[23] = mk(1, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0);

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_outputs", int'(outv), 0);

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].ken, tbl[i].vld, tbl[i].tgt, tbl[i].fb,
               tbl[i].clr);
         checks++;
         if (outv !== tbl[i].exp) begin
            errors++;
            $display("FAIL vec%0d: got %b expected %b", i, outv,
                     tbl[i].exp);
         end
      end

      // accelerate once, STOP->SLOW, then done
      model_en  = 1'b1;
      model_rst = 1'b0;
      acc_n = 0; brk_n = 0; flt_n = 0; acc_first = -1; done_at = -1;
      drive(1, 1, 3, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         drive(1, 0, 3, 0, 0);
         if (accelerate) begin
            acc_n++;
            if (acc_first < 0) acc_first = i;
         end
         if (brake) brk_n++;
         if (fault) flt_n++;
         if (done && done_at < 0) done_at = i;
      end
      chk("accel_count", acc_n, 1);
      chk("accel_cycle", acc_first, 2);
      chk("accel_done_cycle", done_at, 5);
      chk("accel_no_brake_fault", brk_n + flt_n, 0);
      model_en  = 1'b0;
      model_rst = 1'b1;

      // feedback stuck at STOP
      brk_n = 0; fault_at = -1; err_at = -1; bad = 0;
      drive(1, 1, 5, 0, 0);
      for (int i = 1; i <= 60; i++) begin
         drive(1, 0, 5, 0, 0);
         if (accelerate) pulses.push_back(i);
         if (brake) brk_n++;
         if (fault && fault_at < 0) begin
            fault_at = i;
            err_at   = int'(err_code);
         end
      end
      for (int k = 1; k < pulses.size(); k++)
         if (pulses[k] - pulses[k-1] != 6) bad++;
      first = (pulses.size() > 0) ? pulses[0] : -1;
      chk("stuck_pulse_count", pulses.size(), EXP_NP);
      chk("stuck_first_pulse", first, 2);
      chk("stuck_pulse_spacing", bad, 0);
      chk("stuck_no_brake", brk_n, 0);
      chk("stuck_fault_cycle", fault_at, EXP_FA);
      chk("stuck_err_code", err_at, EXP_ERR);

      // reset together with clear_fault
      @(posedge clock);
      #1;
      reset       = 1'b1;
      clear_fault = 1'b1;
      @(posedge clock);
      #1;
      reset       = 1'b0;
      clear_fault = 1'b0;
      @(negedge clock);
      chk("rst_clr_keys", int'(keys), 0);
      chk("rst_clr_fault", int'({fault, err_code}), 0);
      chk("rst_clr_ready", int'(req_ready), 1);

      // key dropped while settling
      drive(1, 0, 5, 0, 0);
      drive(1, 1, 5, 0, 0);
      drive(1, 0, 5, 0, 0);
      drive(1, 0, 5, 0, 0);
      chk("koff_pulse", int'(accelerate), 1);
      drive(0, 0, 5, 0, 0);
      drive(0, 0, 5, 0, 0);
      chk("koff_keys", int'(keys), 0);
      chk("koff_ready", int'(req_ready), 0);
      acc_n = 0;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 5, 0, 0);
         acc_n += int'(accelerate) + int'(brake) + int'(done) +
                  int'(req_ready) + int'(fault);
      end
      chk("koff_quiet", acc_n, 0);
      drive(1, 0, 5, 0, 0);
      chk("koff_ready_back", int'(req_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
